prvp_spi_slave_ctrl_ml: RTL
===========================

Name: prvp_spi_slave_ctrl_ml

Overview:
Parametrised successor SPI-slave protocol controller, between the bit-level shift frontend (rx/tx shift registers with counters) and the bus-side ctrl interface. Adds configurable data/address width, single/dual/quad lanes, per-transfer programmable dummy cycles, per-word address auto-increment and sticky under/overrun status. Runs entirely in the sclk domain. The frontend asserts cs for at least one sclk edge after chip-select release.

Parameters:
DATA_W, 32, data beat width; multiple of 8, 8..64
ADDR_W, 32, address beat width; multiple of 8, 8..32
DUMMY_DEF, 32, dummy cycles after reset; 1..255
ADDR_STEP, 4, ctrl_addr increment per data beat (bytes)

Ports:
sclk  in  1  SPI clock; all state on rising edge
sys_rstn  in  1  asynchronous active-low reset
cs  in  1  synchronous transaction abort, high = deselected
lane_mode  out  2  0 single, 1 dual, 2 quad (3 reserved, treated as quad)
pad_dir  out  1  1 = slave drives data lanes
spi_sod  out  4  per-lane output-disable, 1 = hi-Z
rx_counter  out  8  bits-per-lane-minus-1 for next rx beat
rx_counter_upd  out  1  load rx_counter into frontend
rx_data  in  DATA_W  received beat, LSB-aligned
rx_data_valid  in  1  rx beat complete, 1-cycle pulse
tx_counter  out  8  bits-per-lane-minus-1 for next tx beat
tx_counter_upd  out  1  load tx_counter
tx_data  out  DATA_W  beat to shift out
tx_data_valid  out  1  tx_data load strobe
tx_done  in  1  tx beat complete, 1-cycle pulse
ctrl_rd_wr  out  1  1 = read transaction
ctrl_addr  out  ADDR_W  current beat address
ctrl_addr_valid  out  1  1-cycle pulse per beat address
ctrl_data_rx  out  DATA_W  write data
ctrl_data_rx_valid  out  1  write beat strobe
ctrl_data_rx_ready  in  1  bus accepts write beat
ctrl_data_tx  in  DATA_W  read data
ctrl_data_tx_valid  in  1  read data present
ctrl_data_tx_ready  out  1  pop read data
status  out  2  [0] tx_underrun sticky, [1] rx_overrun sticky

Behaviour:
- Beat length: bits/lanes-1 where lanes = 1/2/4 per lane_mode; CMD beat 8 bits (7/3/1), ADDR beat ADDR_W, DATA beat DATA_W, CFG beat 8.
- Commands: 0x01 WR_CFG (1 byte, [1:0] -> lane_mode), 0x07 WR_DUMMY (1 byte -> dummy count, 0 stored as 1), 0x05 RD_STATUS (1 byte {6'b0,status}, then status cleared), 0x02 WR_MEM, 0x03 RD_MEM (no dummy), 0x0B RD_MEM_FAST (dummy). Other codes -> ERROR.
- States: CMD, CFG_RX, ADDR, DUMMY, DATA_RX, DATA_TX, ERROR.
- CMD: on rx_data_valid decode rx_data[7:0]; WR_CFG/WR_DUMMY -> CFG_RX; RD_STATUS -> DATA_TX with 8-bit counter; mem cmds -> ADDR.
- ADDR: on rx_data_valid latch ctrl_addr, pulse ctrl_addr_valid next cycle; 0x02 -> DATA_RX, 0x03 -> DATA_TX, 0x0B -> DUMMY (rx_counter = dummy-1).
- DUMMY -> DATA_TX on rx_data_valid; pad_dir=1 and spi_sod per lanes asserted the same cycle as state change.
- DATA_RX: each rx_data_valid -> ctrl_data_rx_valid pulse, ctrl_data_rx = rx_data; if ctrl_data_rx_ready low that cycle, set rx_overrun. After the beat ctrl_addr += ADDR_STEP (mod 2^ADDR_W), ctrl_addr_valid pulses. Stays in DATA_RX until cs.
- DATA_TX: on entry and on each tx_done: tx_data_valid + tx_counter_upd pulse, tx_data = ctrl_data_tx, ctrl_data_tx_ready pulse; if ctrl_data_tx_valid low, tx_data = all-ones and tx_underrun set. Address increments after each tx_done.
- WR_CFG takes effect for the next transaction's CMD beat (after cs), not mid-transaction.
- spi_sod: deselected/rx single = 4'b1101, rx dual/quad = 4'b1111, tx single = 4'b1101, dual = 4'b1100, quad = 4'b0000.
- cs high at any edge: state -> CMD, all strobes 0, pad_dir 0, rx_counter = CMD beat length with rx_counter_upd 1; lane_mode, dummy, status retained.
- ERROR: all strobes 0, ignore inputs until cs.
- Reset: state CMD, lane_mode 0, dummy DUMMY_DEF, status 0, pad_dir 0, spi_sod 4'b1101, all strobes 0, counters 8'h07, addr/data 0.
- All outputs registered; one-cycle latency from the input strobe.

Optional Feature:
PRVP_SPI_SLV_WRAP_EN: adds 8-bit command 0x0C WR_WRAP (1 byte, wrap length in beats, 0 = disabled). When defined and nonzero, the address increments wrap to the burst-aligned base after wrap beats. Without the macro, 0x0C is decoded as ERROR and addresses increment linearly.

Test Plan:
- Reset, WR_MEM single, addr 0x1000, 2 beats 0xA5A5A5A5/0x5A5A5A5A -> ctrl_addr 0x1000 then 0x1004, two rx_valid pulses with matching data.
- WR_CFG 0x02, cs toggle, RD_MEM_FAST quad, dummy 8 -> CMD counter 1, ADDR counter 7, rx_counter 7 in DUMMY, spi_sod 0000 in DATA_TX.
- RD_MEM with ctrl_data_tx_valid low -> tx_data 0xFFFFFFFF, RD_STATUS returns 0x01 then 0x00.
- WR_MEM with ctrl_data_rx_ready low on beat -> status[1] set, retained across cs.
- cs mid-DATA_TX -> next edge state CMD, pad_dir 0, no further tx strobes; unknown cmd 0x99 -> no strobes until cs.
- With PRVP_SPI_SLV_WRAP_EN, wrap 4, addr 0x1008 -> addresses 0x1008, 0x100C, 0x1000, 0x1004, 0x1008.

Source files
------------

// File: rtl/prvp_spi_slave_ctrl_ml_if.sv
// Signal bundle between the SPI frontend/bus side and prvp_spi_slave_ctrl_ml.
// The slave modport is the controller's view; master is the frontend/bus view.
interface prvp_spi_slave_ctrl_ml_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              cs;
    logic [1:0]        lane_mode;
    logic              pad_dir;
    logic [3:0]        spi_sod;
    logic [7:0]        rx_counter;
    logic              rx_counter_upd;
    logic [DATA_W-1:0] rx_data;
    logic              rx_data_valid;
    logic [7:0]        tx_counter;
    logic              tx_counter_upd;
    logic [DATA_W-1:0] tx_data;
    logic              tx_data_valid;
    logic              tx_done;
    logic              ctrl_rd_wr;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              ctrl_addr_valid;
    logic [DATA_W-1:0] ctrl_data_rx;
    logic              ctrl_data_rx_valid;
    logic              ctrl_data_rx_ready;
    logic [DATA_W-1:0] ctrl_data_tx;
    logic              ctrl_data_tx_valid;
    logic              ctrl_data_tx_ready;
    logic [1:0]        status;

    modport slave (
        input  cs, rx_data, rx_data_valid, tx_done,
               ctrl_data_rx_ready, ctrl_data_tx, ctrl_data_tx_valid,
        output lane_mode, pad_dir, spi_sod, rx_counter, rx_counter_upd,
               tx_counter, tx_counter_upd, tx_data, tx_data_valid,
               ctrl_rd_wr, ctrl_addr, ctrl_addr_valid, ctrl_data_rx,
               ctrl_data_rx_valid, ctrl_data_tx_ready, status
    );

    modport master (
        output cs, rx_data, rx_data_valid, tx_done,
               ctrl_data_rx_ready, ctrl_data_tx, ctrl_data_tx_valid,
        input  lane_mode, pad_dir, spi_sod, rx_counter, rx_counter_upd,
               tx_counter, tx_counter_upd, tx_data, tx_data_valid,
               ctrl_rd_wr, ctrl_addr, ctrl_addr_valid, ctrl_data_rx,
               ctrl_data_rx_valid, ctrl_data_tx_ready, status
    );
endinterface

// File: rtl/prvp_spi_slave_ctrl_ml.sv
// SPI-slave protocol controller (sclk domain) between the shift frontend and the ctrl bus.
// Optional macro PRVP_SPI_SLV_WRAP_EN adds the WR_WRAP command and wrapping address bursts.
module prvp_spi_slave_ctrl_ml #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DUMMY_DEF = 32,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic                   sclk,
    input  logic                   sys_rstn,
    prvp_spi_slave_ctrl_ml_if.slave bus
);
    localparam logic [7:0] CMD_WR_CFG    = 8'h01;
    localparam logic [7:0] CMD_WR_MEM    = 8'h02;
    localparam logic [7:0] CMD_RD_MEM    = 8'h03;
    localparam logic [7:0] CMD_RD_STATUS = 8'h05;
    localparam logic [7:0] CMD_WR_DUMMY  = 8'h07;
    localparam logic [7:0] CMD_RD_FAST   = 8'h0B;
`ifdef PRVP_SPI_SLV_WRAP_EN
    localparam logic [7:0] CMD_WR_WRAP   = 8'h0C;
`endif

    typedef enum logic [2:0] {
        ST_CMD, ST_CFG_RX, ST_ADDR, ST_DUMMY, ST_DATA_RX, ST_DATA_TX, ST_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [1:0]        cfg_q, cfg_d;
    logic [7:0]        dummy_q, dummy_d;
    logic [1:0]        lane_q, lane_d;
    logic              pad_dir_q, pad_dir_d;
    logic [3:0]        sod_q, sod_d;
    logic [7:0]        rx_cnt_q, rx_cnt_d;
    logic              rx_upd_q, rx_upd_d;
    logic [7:0]        tx_cnt_q, tx_cnt_d;
    logic              tx_upd_q, tx_upd_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rd_wr_q, rd_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic [DATA_W-1:0] data_rx_q, data_rx_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic [1:0]        status_q, status_d;
    logic              load_mem_tx;
    logic              load_stat_tx;
`ifdef PRVP_SPI_SLV_WRAP_EN
    logic [7:0]        wrap_q, wrap_d;
`endif

    // Per-lane beat length minus one; lane_mode 3 behaves as quad.
    function automatic logic [7:0] beat_len(input int unsigned bits, input logic [1:0] mode);
        int unsigned sh;
        sh = (mode == 2'd0) ? 32'd0 : (mode == 2'd1) ? 32'd1 : 32'd2;
        return 8'((bits >> sh) - 32'd1);
    endfunction

    function automatic logic [3:0] sod_for(input logic drive, input logic [1:0] mode);
        logic [3:0] s;
        if (!drive)              s = (mode == 2'd0) ? 4'b1101 : 4'b1111;
        else if (mode == 2'd0)   s = 4'b1101;
        else if (mode == 2'd1)   s = 4'b1100;
        else                     s = 4'b0000;
        return s;
    endfunction

`ifdef PRVP_SPI_SLV_WRAP_EN
    // Wrap back to the aligned burst base once the increment crosses a wrap*step boundary.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] n;
        logic [ADDR_W-1:0] span;
        n    = a + ADDR_W'(ADDR_STEP);
        span = ADDR_W'(wrap_q) * ADDR_W'(ADDR_STEP);
        if (wrap_q != 8'd0 && (n & (span - ADDR_W'(1))) == '0) n = n - span;
        return n;
    endfunction
`else
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(ADDR_STEP);
    endfunction
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cfg_d        = cfg_q;
        dummy_d      = dummy_q;
        lane_d       = lane_q;
        pad_dir_d    = pad_dir_q;
        rx_cnt_d     = rx_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        tx_data_d    = tx_data_q;
        rd_wr_d      = rd_wr_q;
        addr_d       = addr_q;
        data_rx_d    = data_rx_q;
        status_d     = status_q;
        rx_upd_d     = 1'b0;
        tx_upd_d     = 1'b0;
        tx_valid_d   = 1'b0;
        addr_valid_d = 1'b0;
        rx_valid_d   = 1'b0;
        tx_ready_d   = 1'b0;
        load_mem_tx  = 1'b0;
        load_stat_tx = 1'b0;
`ifdef PRVP_SPI_SLV_WRAP_EN
        wrap_d       = wrap_q;
`endif

        if (bus.cs) begin
            // Pending lane config becomes active for the next command beat.
            state_d   = ST_CMD;
            pad_dir_d = 1'b0;
            lane_d    = cfg_q;
            rx_cnt_d  = beat_len(8, cfg_q);
            rx_upd_d  = 1'b1;
        end else begin
            case (state_q)
                ST_CMD: if (bus.rx_data_valid) begin
                    cmd_d = bus.rx_data[7:0];
                    case (bus.rx_data[7:0])
                        CMD_WR_CFG, CMD_WR_DUMMY: begin
                            state_d  = ST_CFG_RX;
                            rx_cnt_d = beat_len(8, lane_q);
                            rx_upd_d = 1'b1;
                        end
`ifdef PRVP_SPI_SLV_WRAP_EN
                        CMD_WR_WRAP: begin
                            state_d  = ST_CFG_RX;
                            rx_cnt_d = beat_len(8, lane_q);
                            rx_upd_d = 1'b1;
                        end
`endif
                        CMD_RD_STATUS: begin
                            state_d      = ST_DATA_TX;
                            load_stat_tx = 1'b1;
                        end
                        CMD_WR_MEM, CMD_RD_MEM, CMD_RD_FAST: begin
                            state_d  = ST_ADDR;
                            rx_cnt_d = beat_len(ADDR_W, lane_q);
                            rx_upd_d = 1'b1;
                            rd_wr_d  = (bus.rx_data[7:0] != CMD_WR_MEM);
                        end
                        default: state_d = ST_ERROR;
                    endcase
                end
                ST_CFG_RX: if (bus.rx_data_valid) begin
                    case (cmd_q)
                        CMD_WR_CFG:   cfg_d   = bus.rx_data[1:0];
                        CMD_WR_DUMMY: dummy_d = (bus.rx_data[7:0] == 8'd0) ? 8'd1 : bus.rx_data[7:0];
`ifdef PRVP_SPI_SLV_WRAP_EN
                        CMD_WR_WRAP:  wrap_d  = bus.rx_data[7:0];
`endif
                        default: ;
                    endcase
                end
                ST_ADDR: if (bus.rx_data_valid) begin
                    addr_d       = ADDR_W'(bus.rx_data);
                    addr_valid_d = 1'b1;
                    case (cmd_q)
                        CMD_WR_MEM: begin
                            state_d  = ST_DATA_RX;
                            rx_cnt_d = beat_len(DATA_W, lane_q);
                            rx_upd_d = 1'b1;
                        end
                        CMD_RD_FAST: begin
                            state_d  = ST_DUMMY;
                            rx_cnt_d = dummy_q - 8'd1;
                            rx_upd_d = 1'b1;
                        end
                        default: begin
                            state_d     = ST_DATA_TX;
                            load_mem_tx = 1'b1;
                        end
                    endcase
                end
                ST_DUMMY: if (bus.rx_data_valid) begin
                    state_d     = ST_DATA_TX;
                    load_mem_tx = 1'b1;
                end
                ST_DATA_RX: begin
                    // Address advances the cycle after the write strobe it belongs to.
                    if (rx_valid_q) begin
                        addr_d       = addr_next(addr_q);
                        addr_valid_d = 1'b1;
                    end
                    if (bus.rx_data_valid) begin
                        rx_valid_d = 1'b1;
                        data_rx_d  = bus.rx_data;
                        if (!bus.ctrl_data_rx_ready) status_d[1] = 1'b1;
                    end
                end
                ST_DATA_TX: if (bus.tx_done) begin
                    if (cmd_q == CMD_RD_STATUS) begin
                        load_stat_tx = 1'b1;
                    end else begin
                        load_mem_tx  = 1'b1;
                        addr_d       = addr_next(addr_q);
                        addr_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase

            if (load_stat_tx) begin
                pad_dir_d  = 1'b1;
                tx_cnt_d   = beat_len(8, lane_q);
                tx_upd_d   = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = DATA_W'(status_q);
                status_d   = 2'b00;
            end
            if (load_mem_tx) begin
                pad_dir_d  = 1'b1;
                tx_cnt_d   = beat_len(DATA_W, lane_q);
                tx_upd_d   = 1'b1;
                tx_valid_d = 1'b1;
                tx_ready_d = 1'b1;
                if (bus.ctrl_data_tx_valid) begin
                    tx_data_d = bus.ctrl_data_tx;
                end else begin
                    tx_data_d   = '1;
                    status_d[0] = 1'b1;
                end
            end
        end

        sod_d = bus.cs ? 4'b1101 : sod_for(pad_dir_d, lane_d);
    end

    always_ff @(posedge sclk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q      <= ST_CMD;
            cmd_q        <= 8'd0;
            cfg_q        <= 2'd0;
            dummy_q      <= 8'(DUMMY_DEF);
            lane_q       <= 2'd0;
            pad_dir_q    <= 1'b0;
            sod_q        <= 4'b1101;
            rx_cnt_q     <= 8'h07;
            rx_upd_q     <= 1'b0;
            tx_cnt_q     <= 8'h07;
            tx_upd_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rd_wr_q      <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            data_rx_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
            status_q     <= 2'b00;
`ifdef PRVP_SPI_SLV_WRAP_EN
            wrap_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cfg_q        <= cfg_d;
            dummy_q      <= dummy_d;
            lane_q       <= lane_d;
            pad_dir_q    <= pad_dir_d;
            sod_q        <= sod_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_upd_q     <= rx_upd_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_upd_q     <= tx_upd_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rd_wr_q      <= rd_wr_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            data_rx_q    <= data_rx_d;
            rx_valid_q   <= rx_valid_d;
            tx_ready_q   <= tx_ready_d;
            status_q     <= status_d;
`ifdef PRVP_SPI_SLV_WRAP_EN
            wrap_q       <= wrap_d;
`endif
        end
    end

    assign bus.lane_mode          = lane_q;
    assign bus.pad_dir            = pad_dir_q;
    assign bus.spi_sod            = sod_q;
    assign bus.rx_counter         = rx_cnt_q;
    assign bus.rx_counter_upd     = rx_upd_q;
    assign bus.tx_counter         = tx_cnt_q;
    assign bus.tx_counter_upd     = tx_upd_q;
    assign bus.tx_data            = tx_data_q;
    assign bus.tx_data_valid      = tx_valid_q;
    assign bus.ctrl_rd_wr         = rd_wr_q;
    assign bus.ctrl_addr          = addr_q;
    assign bus.ctrl_addr_valid    = addr_valid_q;
    assign bus.ctrl_data_rx       = data_rx_q;
    assign bus.ctrl_data_rx_valid = rx_valid_q;
    assign bus.ctrl_data_tx_ready = tx_ready_q;
    assign bus.status             = status_q;
endmodule
